// File: rtl/seq_divider.sv
// Sequential restoring divider: N-bit dividend by D-bit divisor, one quotient bit per clock.
// Start/busy/done handshake with a divide-by-zero flag; results hold until the next accepted start.
module seq_divider #(
    parameter int N = 8,
    parameter int D = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [D-1:0] i_divisor,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_quotient,
    output logic [D-1:0] o_remainder,
    output logic         o_div_by_zero
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         r_state;
    logic [N-1:0]   r_dividend;
    logic [D-1:0]   r_divisor;
    logic [D:0]     r_rem;
    logic [N-1:0]   r_quo;
    logic [CW-1:0]  r_count;
    logic           r_busy;
    logic           r_done;
    logic           r_dbz;
    logic [N-1:0]   r_quotient;
    logic [D-1:0]   r_remainder;

    logic [D:0]     w_shift;
    logic [D:0]     w_diff;
    logic [D:0]     w_rem_next;
    logic           w_ge;
    logic [N-1:0]   w_quo_next;

    // One restoring step; the extra remainder bit keeps the compare from overflowing.
    assign w_shift    = {r_rem[D-1:0], r_dividend[r_count]};
    assign w_ge       = (w_shift >= {1'b0, r_divisor});
    assign w_diff     = w_shift - {1'b0, r_divisor};
    assign w_rem_next = w_ge ? w_diff : w_shift;
    assign w_quo_next = {r_quo[N-2:0], w_ge};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_dividend <= i_dividend;
                        r_divisor  <= i_divisor;
                        r_rem      <= '0;
                        r_quo      <= '0;
                        r_dbz      <= 1'b0;
                        if (i_divisor == '0) begin
                            r_state     <= DONE;
                            r_done      <= 1'b1;
                            r_quotient  <= '1;
                            r_remainder <= '0;
                            r_dbz       <= 1'b1;
                        end else begin
                            r_count <= CW'(N - 1);
                            r_busy  <= 1'b1;
                            r_state <= RUN;
                        end
                    end else if (r_state == DONE) begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    // Last bit: publish results on the same edge that enters DONE.
                    if (r_count == '0) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_quotient  <= w_quo_next;
                        r_remainder <= w_rem_next[D-1:0];
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_div_by_zero = r_dbz;

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential restoring divider: the inverse of the team's combinational 4×4 Wallace-tree multiplier. Takes an 8-bit dividend (a full multiplier product width) and a 4-bit divisor, then returns an 8-bit quotient and a 4-bit remainder, one quotient bit per clock. The block sits beside the multiplier in the arithmetic library and is used to round-trip-check multiplier products. It has a start/busy/done handshake and a divide-by-zero flag.

## Interface
- N, 8, dividend and quotient width
- D, 4, divisor and remainder width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when not busy
- dividend  in  N  numerator, captured on accepted start
- divisor  in  D  denominator, captured on accepted start
- busy  out  1  iteration in progress
- done  out  1  one-cycle pulse: results valid
- quotient  out  N  floor(dividend/divisor)
- remainder  out  D  dividend mod divisor
- div_by_zero  out  1  last operation had divisor==0

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1:
  - Capture dividend and divisor. Clear the partial remainder (D+1 bits) and the quotient shift register. Clear div_by_zero.
  - If divisor==0, go to DONE.
  - Otherwise load bit counter = N-1 and go to RUN.
- IDLE/DONE + start=0:
  - DONE→IDLE.
  - IDLE holds.
- RUN, each cycle, for bit i = counter:
  - r = {r[D-1:0], dividend[i]}.
  - If r ≥ {1'b0,divisor}: r = r − divisor and q[i]=1. Else q[i]=0.
  - If counter==0, go to DONE. Else decrement.
- Entering DONE:
  - Normal case: quotient←q, remainder←r[D-1:0].
  - Divisor==0: quotient←all ones (8'hFF), remainder←0, div_by_zero←1.
- Width rules:
  - The partial remainder is D+1 bits so the compare never overflows.
  - The remainder is always < divisor, so it fits in D bits.
  - Quotient may use all N bits, e.g. 255/1.
- quotient, remainder and div_by_zero hold their values until the next accepted start. They do not change during RUN of a new operation; they update only on entry to DONE.
- start while in RUN is ignored. Operands may change freely after acceptance.
- start held high continuously: a new operation is accepted in every DONE cycle. done pulses once per operation.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal registers 0.
- Accept edge E0 (start=1 in IDLE/DONE):
  - busy=1 from after E0 through E8.
  - Iterations execute at edges E1..E8 (N cycles).
  - After E8: busy=0, done=1 for exactly one cycle, results valid.
  - Latency: N+1 edges from accept to done.
- Divide by zero: done=1 immediately after E0. busy never rises. Latency is 1 edge.
- busy and done are never both 1.
- rst asserted mid-RUN aborts the operation. All outputs go to reset values, and no done is emitted. The first start after rst deasserts is accepted normally.

## Test plan
- 225/15 (multiplier's 15×15 product): after reset, pulse start → busy for 8 cycles, then done one cycle later; quotient=15, remainder=0, div_by_zero=0.
- Back-to-back operations:
  - 47/5 → q=9, r=2.
  - Then 54/6 with start asserted in the DONE cycle → accepted; q=9, r=0 after a further 9 edges.
  - Exactly two done pulses.
- Boundary values:
  - 7/9 → q=0, r=7.
  - 255/1 → q=255, r=0.
  - 255/15 → q=17, r=0.
  - 0/10 → q=0, r=0.
- 100/0 → done one edge after start, busy stays 0, quotient=8'hFF, remainder=0, div_by_zero=1. A following 6/3 → q=2, r=0, div_by_zero=0.
- Start at E0 with 200/7; assert start with 9/3 at E3 → ignored. Result after 9 edges: q=28, r=4, single done.
- Reset mid-operation: start 128/3, assert rst at cycle 4 → all outputs 0 immediately, no done. Release rst and start 15/4 → q=3, r=3 after 9 edges.
